// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - note code constants and the 50 MHz half-period lookup for music_tone_gen.
package music_pkg;

    localparam logic [4:0] NOTE_REST = 5'd0;
    localparam logic [4:0] NOTE_MIN  = 5'd1;
    localparam logic [4:0] NOTE_MAX  = 5'd24;

    typedef logic [16:0] half_period_t;

    // HALF_PERIOD table: clock cycles per half wave at 50 MHz, C4..B5 chromatic.
    function automatic half_period_t half_period(input logic [4:0] code);
        half_period_t hp;
        case (code)
            5'd1:    hp = 17'd95556;
            5'd2:    hp = 17'd90193;
            5'd3:    hp = 17'd85131;
            5'd4:    hp = 17'd80353;
            5'd5:    hp = 17'd75843;
            5'd6:    hp = 17'd71586;
            5'd7:    hp = 17'd67569;
            5'd8:    hp = 17'd63776;
            5'd9:    hp = 17'd60197;
            5'd10:   hp = 17'd56818;
            5'd11:   hp = 17'd53629;
            5'd12:   hp = 17'd50619;
            5'd13:   hp = 17'd47778;
            5'd14:   hp = 17'd45097;
            5'd15:   hp = 17'd42566;
            5'd16:   hp = 17'd40177;
            5'd17:   hp = 17'd37922;
            5'd18:   hp = 17'd35793;
            5'd19:   hp = 17'd33784;
            5'd20:   hp = 17'd31888;
            5'd21:   hp = 17'd30098;
            5'd22:   hp = 17'd28409;
            5'd23:   hp = 17'd26815;
            5'd24:   hp = 17'd25310;
            default: hp = 17'd0;
        endcase
        return hp;
    endfunction

    function automatic logic is_active(input logic [4:0] code);
        return (code >= NOTE_MIN) && (code <= NOTE_MAX);
    endfunction

endpackage

// File: rtl/music_tone_gen_note_qualifier.sv
// rtl/music_tone_gen_note_qualifier.sv - registers the note code and adopts it once held stable.
module note_qualifier #(
    parameter int STABLE_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] music_in,
    output logic [4:0] current_note,
    output logic [4:0] adopt_note,
    output logic       adopt
);
    localparam logic [15:0] STAB_MAX = 16'(STABLE_CYCLES - 1);

    logic [4:0]  in_q;
    logic [4:0]  candidate;
    logic [15:0] stab_cnt;
    logic [15:0] stab_next;

    // stab_cnt counts evaluations beyond the first, so the edge where it reaches
    // STAB_MAX is the STABLE_CYCLES-th consecutive sighting of the code.
    always_comb begin
        stab_next = 16'd0;
        if (in_q == candidate)
            stab_next = (stab_cnt == STAB_MAX) ? stab_cnt : stab_cnt + 16'd1;
        adopt      = (stab_next == STAB_MAX) && (in_q != current_note);
        adopt_note = in_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_q         <= 5'd0;
            candidate    <= 5'd0;
            stab_cnt     <= 16'd0;
            current_note <= 5'd0;
        end else begin
            in_q      <= music_in;
            candidate <= in_q;
            stab_cnt  <= stab_next;
            if (adopt)
                current_note <= in_q;
        end
    end

endmodule

// File: rtl/music_tone_gen.sv
// rtl/music_tone_gen.sv - qualified note code to square-wave tone; define MUSIC_TONE_DECAY_EN for a PWM decay envelope.
module music_tone_gen
    import music_pkg::*;
#(
    parameter int STABLE_CYCLES = 1024,
    parameter int SCALE_SHIFT   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] music_in,
    output logic       audio_out,
    output logic       note_active,
    output logic [4:0] current_note
);
    logic        adopt;
    logic [4:0]  adopt_note;
    logic [16:0] half_cnt;
    logic [16:0] period_raw;
    logic [16:0] period;
    logic        square;

    note_qualifier #(.STABLE_CYCLES(STABLE_CYCLES)) u_qual (
        .clk          (clk),
        .reset        (reset),
        .music_in     (music_in),
        .current_note (current_note),
        .adopt_note   (adopt_note),
        .adopt        (adopt)
    );

    always_comb begin
        period_raw = half_period(current_note) >> SCALE_SHIFT;
        period     = (period_raw == 17'd0) ? 17'd1 : period_raw;
    end

    // A new adoption restarts the tone at phase 0, even mid half-period.
    always_ff @(posedge clk) begin
        if (reset) begin
            note_active <= 1'b0;
            half_cnt    <= 17'd0;
            square      <= 1'b0;
        end else if (adopt) begin
            note_active <= is_active(adopt_note);
            half_cnt    <= 17'd0;
            square      <= 1'b0;
        end else if (!note_active) begin
            half_cnt <= 17'd0;
            square   <= 1'b0;
        end else if (half_cnt == period - 17'd1) begin
            half_cnt <= 17'd0;
            square   <= ~square;
        end else begin
            half_cnt <= half_cnt + 17'd1;
        end
    end

`ifdef MUSIC_TONE_DECAY_EN
    localparam int          DECAY_RAW  = (1 << 20) >> SCALE_SHIFT;
    localparam int          DECAY_LEN  = (DECAY_RAW < 1) ? 1 : DECAY_RAW;
    localparam logic [19:0] DECAY_LAST = 20'(DECAY_LEN - 1);

    logic [3:0]  level;
    logic [3:0]  pwm;
    logic [19:0] decay_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            level     <= 4'd0;
            pwm       <= 4'd0;
            decay_cnt <= 20'd0;
        end else begin
            pwm <= pwm + 4'd1;
            if (adopt) begin
                decay_cnt <= 20'd0;
                if (is_active(adopt_note))
                    level <= 4'd15;
            end else if (note_active && level != 4'd0) begin
                if (decay_cnt == DECAY_LAST) begin
                    decay_cnt <= 20'd0;
                    level     <= level - 4'd1;
                end else begin
                    decay_cnt <= decay_cnt + 20'd1;
                end
            end
        end
    end

    assign audio_out = square & (pwm < level);
`else
    assign audio_out = square;
`endif

endmodule

// File: tb/tb_music_tone_gen.sv
// tb/tb_music_tone_gen.sv - randomized and directed checks of music_tone_gen against a behavioural model.
module tb_music_tone_gen;
    localparam int STABLE = 4;
    localparam int SHIFT  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] music_in = 5'd10;
    logic       audio_out;
    logic       note_active;
    logic [4:0] current_note;

    int errors = 0;
    int checks = 0;

    int tab[32] = '{0, 95556, 90193, 85131, 80353, 75843, 71586, 67569, 63776, 60197,
                    56818, 53629, 50619, 47778, 45097, 42566, 40177, 37922, 35793, 33784,
                    31888, 30098, 28409, 26815, 25310, 0, 0, 0, 0, 0, 0, 0};

    music_tone_gen #(.STABLE_CYCLES(STABLE), .SCALE_SHIFT(SHIFT)) dut (
        .clk          (clk),
        .reset        (reset),
        .music_in     (music_in),
        .audio_out    (audio_out),
        .note_active  (note_active),
        .current_note (current_note)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int per(input int code);
        int p;
        p = tab[code] >> SHIFT;
        return (p < 1) ? 1 : p;
    endfunction

    // Model: the code seen by the qualifier is music_in one edge late; it is adopted
    // after STABLE consecutive sightings; the tone is a function of cycles since adoption.
    int m_inq = 0, run_val = 0, run_len = 1, m_cur = 0, m_k = 0;
    bit m_act = 0;

    always begin
        @(posedge clk);
        if (reset) begin
            m_inq = 0; run_val = 0; run_len = 1; m_cur = 0; m_k = 0; m_act = 0;
        end else begin
            if (m_inq == run_val) begin
                if (run_len < 1000000) run_len++;
            end else begin
                run_val = m_inq;
                run_len = 1;
            end
            if (run_len >= STABLE && run_val != m_cur) begin
                m_cur = run_val;
                m_k   = 0;
                m_act = (m_cur >= 1 && m_cur <= 24);
            end else if (m_act) begin
                m_k++;
            end
            m_inq = music_in;
        end
        #2;
        chk("current_note", current_note, m_cur);
        chk("note_active", note_active, m_act);
`ifndef MUSIC_TONE_DECAY_EN
        chk("audio_out", audio_out, m_act ? ((m_k / per(m_cur)) % 2) : 0);
`endif
    end

    task automatic wait_level(input logic lvl, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (audio_out !== lvl && n < 2000);
    endtask

    initial begin
        int n;
        int code;
        int len;
        int r;

        reset = 1'b1;
        music_in = 5'd10;
        repeat (3) begin
            @(negedge clk);
            chk("reset_audio", audio_out, 0);
            chk("reset_note", current_note, 0);
            chk("reset_active", note_active, 0);
        end
        music_in = 5'd0;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        music_in = 5'd10;
        repeat (4) @(negedge clk);
        chk("pre_adopt_edge4", current_note, 0);
        @(negedge clk);
        chk("adopt_edge5", current_note, 10);
        chk("adopt_active", note_active, 1);
        chk("adopt_audio", audio_out, 0);
        wait_level(1'b1, n);
        chk("a4_first_rise", n, 221);
        wait_level(1'b0, n);
        chk("a4_half_period", n, 221);

        music_in = 5'd13;
        repeat (3) @(negedge clk);
        music_in = 5'd10;
        repeat (12) @(negedge clk);
        chk("glitch_ignored", current_note, 10);

        music_in = 5'd13;
        repeat (5) @(negedge clk);
        chk("switch_note", current_note, 13);
        chk("switch_audio", audio_out, 0);
        wait_level(1'b1, n);
        chk("c5_first_rise", n, 186);
        wait_level(1'b0, n);
        chk("c5_half_period", n, 186);

        music_in = 5'd27;
        repeat (5) @(negedge clk);
        chk("rest27_note", current_note, 27);
        chk("rest27_active", note_active, 0);
        repeat (50) @(negedge clk);
        chk("rest27_audio", audio_out, 0);

        music_in = 5'd10;
        repeat (5) @(negedge clk);
        wait_level(1'b1, n);
        chk("pre_reset_rise", n, 221);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_audio", audio_out, 0);
        chk("midreset_note", current_note, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("readopt_edge4", current_note, 0);
        @(negedge clk);
        chk("readopt_edge5", current_note, 10);

        for (int seg = 0; seg < 150; seg++) begin
            r = $urandom_range(0, 9);
            code = (r < 3) ? 10 + 3 * $urandom_range(0, 1) : $urandom_range(0, 31);
            len = (r < 5) ? $urandom_range(1, 6) : $urandom_range(20, 500);
            music_in = 5'(code);
            if ($urandom_range(0, 29) == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                reset = 1'b0;
            end
            repeat (len) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
